// File: rtl/count_run_ctrl_if.sv
// count_run_ctrl_if
//   Command channel for the counter run sequencer. A command names the first
//   counter value of a run, the terminal value, and how many extra repeats
//   to perform. Transfer happens on a cycle where cmd_valid and cmd_ready
//   are both high.
// Signals
//   cmd_valid  master -> slave   command offered
//   cmd_ready  slave  -> master  sequencer can take a command this cycle
//   cmd_start  master -> slave   first counter value of each run (CW bits)
//   cmd_end    master -> slave   terminal counter value of each run (CW bits)
//   cmd_reps   master -> slave   extra repeats, 0 means a single run (REPW bits)
interface count_run_ctrl_if #(
  parameter int CW   = 8,
  parameter int REPW = 4
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [CW-1:0]   cmd_start;
  logic [CW-1:0]   cmd_end;
  logic [REPW-1:0] cmd_reps;

  // The command source drives the payload and valid, and sees ready.
  modport master (
    output cmd_valid,
    output cmd_start,
    output cmd_end,
    output cmd_reps,
    input  cmd_ready
  );

  // The sequencer sees the payload and valid, and drives ready.
  modport slave (
    input  cmd_valid,
    input  cmd_start,
    input  cmd_end,
    input  cmd_reps,
    output cmd_ready
  );
endinterface

// File: rtl/count_run_ctrl.sv
// count_run_ctrl
//   Sequencer for an external up-counter. Takes a run command (start, end,
//   repeats) and drives the counter's load/enable so it steps start..end
//   (wrapping through the counter's natural overflow when end < start),
//   repeated reps+1 times. run_done pulses for one cycle after the last run.
//   The counter itself lives outside this block; its registered value comes
//   back in on count_in.
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   cmd           command channel (count_run_ctrl_if.slave)
//   pause         holds the counter while high, only honoured while running
//   ctr_load      counter load strobe (the counter gives load priority)
//   ctr_load_val  value for the counter to load
//   ctr_en        counter increment enable
//   count_in      counter's registered output
//   busy          high whenever a command is being processed
//   rep_idx       0-based index of the current run
//   run_done      one-cycle pulse after the last run ends
//   abort         (RUN_CTRL_ABORT_EN only) cancel the command in progress
//   aborted       (RUN_CTRL_ABORT_EN only) one-cycle pulse on return to idle
// Configuration
//   RUN_CTRL_ABORT_EN  when defined, adds the abort input and aborted output.
module count_run_ctrl #(
  parameter int CW   = 8,
  parameter int REPW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  count_run_ctrl_if.slave cmd,
  input  logic            pause,
`ifdef RUN_CTRL_ABORT_EN
  input  logic            abort,
  output logic            aborted,
`endif
  output logic            ctr_load,
  output logic [CW-1:0]   ctr_load_val,
  output logic            ctr_en,
  input  logic [CW-1:0]   count_in,
  output logic            busy,
  output logic [REPW-1:0] rep_idx,
  output logic            run_done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   start_q;
  logic [CW-1:0]   end_q;
  logic [REPW-1:0] reps_q;

  logic at_end;
  logic last_rep;
  logic abort_hit;

  // The terminal check looks at the counter's registered value, so it still
  // fires while pause is high: a paused counter sitting on end_q is done.
  assign at_end   = (count_in == end_q);
  assign last_rep = (rep_idx == reps_q);

  // An abort only matters once a command has been taken; in idle there is
  // nothing to cancel. Without the abort option this is tied off so the
  // state machine below reads the same in both builds.
`ifdef RUN_CTRL_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // The load value is simply the latched start; it only matters while
  // ctr_load is high, and holding it avoids an extra register.
  assign ctr_load_val = start_q;

  // The enable has to react to pause and count_in in the same cycle,
  // otherwise the counter would overshoot end by one, so it is the only
  // output not taken straight from a register. Abort also kills it at once.
  assign ctr_en = (state == RUN) && !pause && !at_end && !abort_hit;

  // Main sequencer. Outputs other than ctr_en are registered here alongside
  // the state so each one changes on the same edge as the state it belongs
  // to: ready/busy track idle, ctr_load marks the one-cycle load state and
  // run_done marks the one-cycle done state. Each repeat goes back through
  // LOAD, which is why run k+1 starts two cycles after run k reaches end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      start_q       <= '0;
      end_q         <= '0;
      reps_q        <= '0;
      rep_idx       <= '0;
      cmd.cmd_ready <= 1'b1;
      ctr_load      <= 1'b0;
      busy          <= 1'b0;
      run_done      <= 1'b0;
`ifdef RUN_CTRL_ABORT_EN
      aborted       <= 1'b0;
`endif
    end else begin
      ctr_load <= 1'b0;
      run_done <= 1'b0;
`ifdef RUN_CTRL_ABORT_EN
      aborted  <= 1'b0;
`endif
      if (abort_hit) begin
        state         <= IDLE;
        cmd.cmd_ready <= 1'b1;
        busy          <= 1'b0;
`ifdef RUN_CTRL_ABORT_EN
        aborted       <= 1'b1;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (cmd.cmd_valid && cmd.cmd_ready) begin
              start_q       <= cmd.cmd_start;
              end_q         <= cmd.cmd_end;
              reps_q        <= cmd.cmd_reps;
              rep_idx       <= '0;
              state         <= LOAD;
              ctr_load      <= 1'b1;
              cmd.cmd_ready <= 1'b0;
              busy          <= 1'b1;
            end
          end
          LOAD: begin
            state <= RUN;
          end
          RUN: begin
            if (at_end) begin
              if (last_rep) begin
                state    <= DONE;
                run_done <= 1'b1;
              end else begin
                rep_idx  <= rep_idx + 1'b1;
                state    <= LOAD;
                ctr_load <= 1'b1;
              end
            end
          end
          DONE: begin
            state         <= IDLE;
            cmd.cmd_ready <= 1'b1;
            busy          <= 1'b0;
          end
          default: begin
            state         <= IDLE;
            cmd.cmd_ready <= 1'b1;
            busy          <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_run_ctrl.sv
// tb_count_run_ctrl
//   Drives count_run_ctrl with directed and random run commands against a
//   behavioural 8-bit counter. Each accepted command pushes its expected
//   outcome onto a scoreboard queue; a monitor watches the counter values,
//   run indices and run_done pulses and checks them against that outcome.
module tb_count_run_ctrl;
  localparam int CW   = 8;
  localparam int REPW = 4;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  count_run_ctrl_if #(.CW(CW), .REPW(REPW)) cmd_if ();

  logic            pause;
  logic            pause_force;
  logic            rand_pause_en;
  logic            rand_bit;
  logic            abort;
  logic            ctr_load;
  logic [CW-1:0]   ctr_load_val;
  logic            ctr_en;
  logic [CW-1:0]   count_in;
  logic            busy;
  logic [REPW-1:0] rep_idx;
  logic            run_done;
`ifdef RUN_CTRL_ABORT_EN
  logic            aborted;
`endif

  count_run_ctrl #(.CW(CW), .REPW(REPW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd          (cmd_if),
    .pause        (pause),
`ifdef RUN_CTRL_ABORT_EN
    .abort        (abort),
    .aborted      (aborted),
`endif
    .ctr_load     (ctr_load),
    .ctr_load_val (ctr_load_val),
    .ctr_en       (ctr_en),
    .count_in     (count_in),
    .busy         (busy),
    .rep_idx      (rep_idx),
    .run_done     (run_done)
  );

  // Pause is the directed force OR'd with an optional random component, so
  // directed pauses take effect in the same cycle they are written.
  assign pause = pause_force | (rand_pause_en & rand_bit);

  always @(negedge clk) rand_bit = ($urandom_range(0, 3) == 0);

  // Behavioural external counter: load beats enable, wraps at 255, and is
  // not touched by the sequencer's reset.
  logic [CW-1:0] cnt;
  initial cnt = '0;
  always @(posedge clk) begin
    if (ctr_load)    cnt <= ctr_load_val;
    else if (ctr_en) cnt <= cnt + 8'd1;
  end
  assign count_in = cnt;

  int cyc;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] s;
    logic [7:0] e;
    logic [3:0] reps;
    int         acc;
    bit         lat_chk;
    int         extra;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;
  int   last_done_cyc;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  task automatic printSummary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic finishNow(input string why);
    checks++;
    failures++;
    $display("[TB] FAIL timeout_%s: bound expired at cycle %0d", why, cyc);
    printSummary();
    $finish;
  endtask

  // Offer one command and hold it until accepted. If the sequencer was busy
  // when the command was first offered, it must be taken on the first idle
  // cycle, i.e. the cycle right after the previous run_done.
  task automatic applyStimulus(input logic [7:0] s, input logic [7:0] e,
                               input logic [3:0] r, input bit lat_chk,
                               input int extra);
    exp_t ex;
    bit   was_busy;
    int   n;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_start = s;
    cmd_if.cmd_end   = e;
    cmd_if.cmd_reps  = r;
    was_busy = !cmd_if.cmd_ready;
    n = 0;
    while (!cmd_if.cmd_ready) begin
      @(negedge clk);
      n++;
      if (n > 3000) finishNow("accept");
    end
    ex.s       = s;
    ex.e       = e;
    ex.reps    = r;
    ex.acc     = cyc;
    ex.lat_chk = lat_chk;
    ex.extra   = extra;
    sb.push_back(ex);
    if (was_busy) checkOutput("accept_after_done", cyc, last_done_cyc + 1);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      n++;
      if (n > 5000) finishNow("drain");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cmd_ready"},    cmd_if.cmd_ready, 1);
    checkOutput({tag, "_ctr_load"},     ctr_load, 0);
    checkOutput({tag, "_ctr_en"},       ctr_en, 0);
    checkOutput({tag, "_ctr_load_val"}, ctr_load_val, 0);
    checkOutput({tag, "_busy"},         busy, 0);
    checkOutput({tag, "_rep_idx"},      rep_idx, 0);
    checkOutput({tag, "_run_done"},     run_done, 0);
  endtask

  // Monitor: samples just after each falling edge. It gathers the distinct
  // counter values seen in each run (pause just repeats a value) and the
  // run index of each run, and on run_done compares them with the value
  // list the popped command implies.
  logic [7:0] obs_vals[$];
  int         run_lens[$];
  int         obs_rep[$];
  bit         prev_load;
  bit         have_last;
  logic [7:0] last_val;
  bit         in_run;

  initial begin
    exp_t       ex;
    logic [7:0] exp_vals[$];
    int         len;
    int         bad;
    prev_load = 1'b0;
    have_last = 1'b0;
    last_val  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_load = 1'b0;
        continue;
      end
      in_run = busy && !ctr_load && !run_done;
      if (ctr_load && sb.size() > 0) checkOutput("load_value", ctr_load_val, sb[0].s);
      if (prev_load && in_run) begin
        if (rep_idx == 0) begin
          obs_vals.delete();
          run_lens.delete();
          obs_rep.delete();
        end
        run_lens.push_back(0);
        obs_rep.push_back(int'(rep_idx));
        have_last = 1'b0;
      end
      if (in_run && run_lens.size() > 0) begin
        if (!have_last || count_in != last_val) begin
          obs_vals.push_back(count_in);
          run_lens[run_lens.size()-1]++;
          last_val  = count_in;
          have_last = 1'b1;
        end
      end
      if (in_run && sb.size() > 0)
        checkOutput("ctr_en", ctr_en, 32'(!pause && !abort && (count_in != sb[0].e)));
      if (run_done) begin
        checkOutput("done_has_command", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          ex  = sb.pop_front();
          len = ((int'(ex.e) - int'(ex.s)) & 255) + 1;
          exp_vals.delete();
          for (int k = 0; k <= int'(ex.reps); k++)
            for (int v = 0; v < len; v++)
              exp_vals.push_back(8'(int'(ex.s) + v));
          checkOutput("run_count", run_lens.size(), int'(ex.reps) + 1);
          checkOutput("value_count", obs_vals.size(), exp_vals.size());
          bad = 0;
          for (int i = 0; i < obs_vals.size() && i < exp_vals.size(); i++)
            if (obs_vals[i] != exp_vals[i]) bad++;
          checkOutput("value_seq_mismatches", bad, 0);
          bad = 0;
          for (int k = 0; k < obs_rep.size(); k++)
            if (obs_rep[k] != k) bad++;
          checkOutput("rep_idx_seq_mismatches", bad, 0);
          checkOutput("rep_idx_at_done", rep_idx, ex.reps);
          if (ex.lat_chk)
            checkOutput("done_latency", cyc - ex.acc,
                        (int'(ex.reps) + 1) * (len + 1) + 1 + ex.extra);
        end
        last_done_cyc = cyc;
      end
      prev_load = ctr_load;
    end
  end

  // Main sequence: reset, directed scenarios, random commands, mid-run
  // reset, and the abort scenario when that option is built in.
  initial begin
    logic [7:0] s;
    checks           = 0;
    failures         = 0;
    last_done_cyc    = -10;
    rst_n            = 1'b0;
    pause_force      = 1'b0;
    rand_pause_en    = 1'b0;
    abort            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_start = '0;
    cmd_if.cmd_end   = '0;
    cmd_if.cmd_reps  = '0;

    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed: single run, wrap run back-to-back");
    applyStimulus(8'd10, 8'd13, 4'd0, 1'b1, 0);
    applyStimulus(8'd254, 8'd1, 4'd0, 1'b1, 0);

    $display("[TB] directed: repeats with a 3-cycle pause in run 1");
    applyStimulus(8'd5, 8'd7, 4'd2, 1'b1, 3);
    repeat (5) @(negedge clk);
    pause_force = 1'b1;
    repeat (3) @(negedge clk);
    pause_force = 1'b0;

    $display("[TB] directed: degenerate start==end");
    applyStimulus(8'd42, 8'd42, 4'd0, 1'b1, 0);
    applyStimulus(8'd42, 8'd42, 4'd2, 1'b1, 0);
    waitDrain();

    $display("[TB] random commands, no pause");
    for (int i = 0; i < 10; i++) begin
      s = 8'($urandom_range(0, 255));
      applyStimulus(s, 8'(s + 8'($urandom_range(0, 12))), 4'($urandom_range(0, 3)), 1'b1, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    waitDrain();

    $display("[TB] random commands, random pause");
    rand_pause_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s = 8'($urandom_range(0, 255));
      applyStimulus(s, 8'(s + 8'($urandom_range(0, 12))), 4'($urandom_range(0, 3)), 1'b0, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    waitDrain();
    rand_pause_en = 1'b0;

    $display("[TB] reset asserted mid-run");
    applyStimulus(8'd0, 8'd200, 4'd0, 1'b0, 0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetValues("midrun_reset");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_cmd_ready", cmd_if.cmd_ready, 1);
    applyStimulus(8'd3, 8'd6, 4'd1, 1'b1, 0);
    waitDrain();

`ifdef RUN_CTRL_ABORT_EN
    begin
      int n;
      $display("[TB] abort in RUN at count 12 of 10..20");
      applyStimulus(8'd10, 8'd20, 4'd0, 1'b0, 0);
      n = 0;
      while (!(count_in == 8'd12 && busy && !ctr_load)) begin
        @(negedge clk);
        n++;
        if (n > 200) finishNow("abort_wait");
      end
      abort = 1'b1;
      #1;
      checkOutput("abort_ctr_en", ctr_en, 0);
      @(negedge clk);
      abort = 1'b0;
      #1;
      checkOutput("aborted_pulse", aborted, 1);
      checkOutput("abort_no_run_done", run_done, 0);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_cmd_ready", cmd_if.cmd_ready, 1);
      if (sb.size() > 0) void'(sb.pop_front());
      @(negedge clk);
      #1;
      checkOutput("aborted_one_cycle", aborted, 0);
    end
`endif

    checkOutput("scoreboard_drained", sb.size(), 0);
    printSummary();
    $finish;
  end

endmodule
